instr_fetch: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-ROM address,
//  and loads the 64-bit IF_ID register consumed by ID (IF_ID[63:32]=PC+4, IF_ID[31:0]=instr).

---
 rtl/instr_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch : IF stage of the 5-stage MIPS pipeline.
//   Owns the fetch PC, addresses the combinational instruction ROM and loads
//   the 64-bit IF_ID register {PC+4, instruction} consumed by ID.
//   Applies exception/interrupt vectoring, load-use stall and ID redirects
//   (JR > J > branch); every redirect writes a NOP bubble into IF_ID.
//
// Optional feature macro: IF_PERF_CNT_EN
//   Defined   : adds saturating perf counters perf_fetch / perf_stall /
//               perf_flush (CNT_W bits each).
//   Undefined : counter ports and logic are absent; behaviour is identical.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INTR_PC  = 32'h8000_0004,
    parameter logic [31:0] EXCP_PC  = 32'h8000_0008,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_IF_ID_Write,
    input  logic             Z,
    input  logic             J,
    input  logic             JR,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      jr_target,
    input  logic             interrupt,
    input  logic             exception,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      PC,
`ifdef IF_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
`endif
    output logic [63:0]      IF_ID
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    // IF_ID payload as seen by ID
    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // Per-edge action, in priority order
    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_STALL = 3'd1,
        SEL_EXCP  = 3'd2,
        SEL_INTR  = 3'd3,
        SEL_JR    = 3'd4,
        SEL_J     = 3'd5,
        SEL_BR    = 3'd6
    } sel_e;

    // A zero-width counter is meaningless; catch it at elaboration
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("instr_fetch: CNT_W must be at least 1");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    if_id_t          if_id_q;
    if_id_t          if_id_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] redirect_pc;
    logic            is_flush;
    sel_e            sel;

    assign pc4       = pc_q + INSTR_BYTES;
    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign IF_ID     = if_id_q;

    // Choose this edge's action; vectors beat stall, stall masks ID redirects
    always_comb begin
        sel = SEL_SEQ;
        if (exception) begin
            sel = SEL_EXCP;
        end else if (interrupt) begin
            sel = SEL_INTR;
        end else if (!PC_IF_ID_Write) begin
            sel = SEL_STALL;
        end else if (JR) begin
            sel = SEL_JR;
        end else if (J) begin
            sel = SEL_J;
        end else if (Z) begin
            sel = SEL_BR;
        end
    end

    // Redirect target for the flush cases
    always_comb begin
        redirect_pc = pc4;
        is_flush    = 1'b1;
        unique case (sel)
            SEL_EXCP:  redirect_pc = EXCP_PC;
            SEL_INTR:  redirect_pc = INTR_PC;
            SEL_JR:    redirect_pc = jr_target;
            SEL_J:     redirect_pc = jump_target;
            SEL_BR:    redirect_pc = branch_target;
            default:   is_flush    = 1'b0;
        endcase
    end

    // Next PC and IF_ID; a flush loads {tgt+4, NOP} so $k0 recovery sees tgt
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        if (is_flush) begin
            pc_d             = redirect_pc;
            if_id_d.pc_plus4 = redirect_pc + INSTR_BYTES;
            if_id_d.instr    = NOP_WORD;
        end else if (sel == SEL_SEQ) begin
            pc_d             = pc4;
            if_id_d.pc_plus4 = pc4;
            if_id_d.instr    = imem_rdata;
        end
    end

    // PC and IF_ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign perf_fetch = fetch_cnt_q;
    assign perf_stall = stall_cnt_q;
    assign perf_flush = flush_cnt_q;

    // Saturating event counters, observation only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (sel == SEL_SEQ && fetch_cnt_q != '1) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (sel == SEL_STALL && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (is_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch : self-checking bench for instr_fetch.
//   Directed scenarios plus randomized traffic against a behavioural model of
//   the fetch rules. Perf-counter scenario only when IF_PERF_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] INT_PC = 32'h8000_0004;
    localparam logic [31:0] EXC_PC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b1;
    logic        z = 1'b0;
    logic        j = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] br_tgt = '0;
    logic [31:0] j_tgt = '0;
    logic [31:0] jr_tgt = '0;
    logic        intr = 1'b0;
    logic        excp = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [63:0] if_id;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc = RST_PC;
    logic [63:0] m_ifid = '0;
    int          m_fetch = 0;
    int          m_stall = 0;
    int          m_flush = 0;

    always #5 clk = ~clk;

    // Instruction ROM contents: a fixed scramble of the address
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = rom(imem_addr);

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_flush;
    logic [3:0]  p4_fetch, p4_stall, p4_flush;
    logic [31:0] u4_addr, u4_pc;
    logic [63:0] u4_ifid;

    instr_fetch #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .PC_IF_ID_Write(wr), .Z(z), .J(j), .JR(jr),
        .branch_target(br_tgt), .jump_target(j_tgt), .jr_target(jr_tgt),
        .interrupt(intr), .exception(excp), .imem_rdata(rom(u4_addr)),
        .imem_addr(u4_addr), .PC(u4_pc),
        .perf_fetch(p4_fetch), .perf_stall(p4_stall), .perf_flush(p4_flush),
        .IF_ID(u4_ifid)
    );
`endif

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .PC_IF_ID_Write(wr), .Z(z), .J(j), .JR(jr),
        .branch_target(br_tgt), .jump_target(j_tgt), .jr_target(jr_tgt),
        .interrupt(intr), .exception(excp), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .PC(pc),
`ifdef IF_PERF_CNT_EN
        .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush),
`endif
        .IF_ID(if_id)
    );

    task automatic set_idle();
        wr = 1'b1; z = 1'b0; j = 1'b0; jr = 1'b0; intr = 1'b0; excp = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ifid = '0; m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    // Apply the fetch rules for the upcoming edge to the model
    task automatic model_step();
        logic [31:0] tgt;
        if (!rst_n) begin
            m_pc = RST_PC; m_ifid = '0;
            return;
        end
        if (excp)         tgt = EXC_PC;
        else if (intr)    tgt = INT_PC;
        else if (!wr) begin
            m_stall++;
            return;
        end
        else if (jr)      tgt = jr_tgt;
        else if (j)       tgt = j_tgt;
        else if (z)       tgt = br_tgt;
        else begin
            m_ifid = {m_pc + 32'd4, rom(m_pc)};
            m_pc   = m_pc + 32'd4;
            m_fetch++;
            return;
        end
        m_pc   = tgt;
        m_ifid = {tgt + 32'd4, 32'h0000_0000};
        m_flush++;
    endtask

    // One clock: advance the model, take the edge, settle away from it
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_addr;
        rst_n = 1'b0;
        set_idle();
        @(posedge clk); #1;
        n_checks++;
        if (pc !== RST_PC || if_id !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_hold: PC=%h IF_ID=%h, want %h / 0", pc, if_id, RST_PC);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_addr = RST_PC + 32'(4 * i);
            n_checks++;
            if (imem_addr !== exp_addr) begin
                n_errors++;
                $display("FAIL reset_seq_addr%0d: imem_addr=%h want %h", i, imem_addr, exp_addr);
            end
            cycle();
            n_checks++;
            if (if_id !== {exp_addr + 32'd4, rom(exp_addr)}) begin
                n_errors++;
                $display("FAIL reset_seq_ifid%0d: IF_ID=%h want %h", i, if_id,
                         {exp_addr + 32'd4, rom(exp_addr)});
            end
        end
        // Mid-run async reset: takes effect without any clock edge
        for (int i = 0; i < 2; i++) cycle();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (pc !== RST_PC || if_id !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_async: PC=%h IF_ID=%h, want %h / 0", pc, if_id, RST_PC);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stall();
        logic [63:0] frozen;
        set_idle();
        jr = 1'b1; jr_tgt = 32'h8000_0010;
        cycle();
        jr = 1'b0;
        frozen = if_id;
        wr = 1'b0; z = 1'b1; br_tgt = 32'h8000_0200;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (pc !== 32'h8000_0010 || if_id !== frozen) begin
                n_errors++;
                $display("FAIL stall_hold%0d: PC=%h IF_ID=%h want 80000010 / %h", i, pc, if_id, frozen);
            end
        end
        wr = 1'b1; z = 1'b0;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0014 || if_id !== {32'h8000_0014, rom(32'h8000_0010)}) begin
            n_errors++;
            $display("FAIL stall_release: PC=%h IF_ID=%h want 80000014 / %h", pc, if_id,
                     {32'h8000_0014, rom(32'h8000_0010)});
        end
    endtask

    task automatic test_branch();
        set_idle();
        z = 1'b1; br_tgt = 32'h8000_0040;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0040 || if_id !== 64'h8000_0044_0000_0000) begin
            n_errors++;
            $display("FAIL branch_taken: PC=%h IF_ID=%h want 80000040 / 8000004400000000", pc, if_id);
        end
        jr = 1'b1; j = 1'b1; z = 1'b1;
        jr_tgt = 32'h8000_0100; j_tgt = 32'h8000_0300; br_tgt = 32'h8000_0500;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0100 || if_id !== 64'h8000_0104_0000_0000) begin
            n_errors++;
            $display("FAIL redirect_prio: PC=%h IF_ID=%h want 80000100 / 8000010400000000", pc, if_id);
        end
        jr = 1'b0; z = 1'b0; j = 1'b1; j_tgt = 32'h8000_0300;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0300) begin
            n_errors++;
            $display("FAIL jump: PC=%h want 80000300", pc);
        end
        set_idle();
    endtask

    task automatic test_vectors();
        set_idle();
        wr = 1'b0; intr = 1'b1;
        cycle();
        n_checks++;
        if (pc !== INT_PC || if_id !== {INT_PC + 32'd4, 32'h0}) begin
            n_errors++;
            $display("FAIL intr_in_stall: PC=%h IF_ID=%h want %h / %h", pc, if_id,
                     INT_PC, {INT_PC + 32'd4, 32'h0});
        end
        wr = 1'b1; excp = 1'b1; jr = 1'b1; jr_tgt = 32'h1234_5678;
        cycle();
        n_checks++;
        if (pc !== EXC_PC || if_id !== {EXC_PC + 32'd4, 32'h0}) begin
            n_errors++;
            $display("FAIL excp_over_intr: PC=%h IF_ID=%h want %h / %h", pc, if_id,
                     EXC_PC, {EXC_PC + 32'd4, 32'h0});
        end
        set_idle();
    endtask

    task automatic test_wrap();
        set_idle();
        jr = 1'b1; jr_tgt = 32'hFFFF_FFFC;
        cycle();
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || if_id !== 64'h0000_0000_0000_0000) begin
            n_errors++;
            $display("FAIL wrap_jr: PC=%h IF_ID=%h want FFFFFFFC / 0", pc, if_id);
        end
        jr = 1'b0;
        cycle();
        n_checks++;
        if (pc !== 32'h0000_0000 || if_id !== {32'h0000_0000, rom(32'hFFFF_FFFC)}) begin
            n_errors++;
            $display("FAIL wrap_seq: PC=%h IF_ID=%h want 0 / %h", pc, if_id,
                     {32'h0000_0000, rom(32'hFFFF_FFFC)});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr     = ($urandom_range(0, 4) != 0);
            z      = ($urandom_range(0, 5) == 0);
            j      = ($urandom_range(0, 5) == 0);
            jr     = ($urandom_range(0, 5) == 0);
            intr   = ($urandom_range(0, 15) == 0);
            excp   = ($urandom_range(0, 15) == 0);
            br_tgt = {$urandom(), 2'b00} >> 0;
            br_tgt = {br_tgt[31:2], 2'b00};
            j_tgt  = $urandom();
            j_tgt  = {j_tgt[31:2], 2'b00};
            jr_tgt = $urandom();
            cycle();
            n_checks++;
            if (pc !== m_pc || if_id !== m_ifid || imem_addr !== m_pc) begin
                n_errors++;
                $display("FAIL random%0d: PC=%h IF_ID=%h addr=%h want %h / %h", i,
                         pc, if_id, imem_addr, m_pc, m_ifid);
            end
        end
        set_idle();
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        set_idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) cycle();
        wr = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        wr = 1'b1; z = 1'b1; br_tgt = 32'h8000_0080;
        for (int i = 0; i < 2; i++) cycle();
        z = 1'b0;
        n_checks++;
        if (perf_fetch !== 32'(m_fetch) || perf_stall !== 32'(m_stall) || perf_flush !== 32'(m_flush)
            || m_fetch != 10 || m_stall != 3 || m_flush != 2) begin
            n_errors++;
            $display("FAIL perf_counts: fetch=%0d stall=%0d flush=%0d want 10/3/2",
                     perf_fetch, perf_stall, perf_flush);
        end
        for (int i = 0; i < 10; i++) cycle();
        n_checks++;
        if (perf_fetch !== 32'd20 || p4_fetch !== 4'hF || p4_stall !== 4'd3 || p4_flush !== 4'd2) begin
            n_errors++;
            $display("FAIL perf_saturate: fetch=%0d fetch4=%h stall4=%h flush4=%h want 20/F/3/2",
                     perf_fetch, p4_fetch, p4_stall, p4_flush);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_vectors();
        test_wrap();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
